mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Three-way arbiter and sequencer for the single-port 64 KiB system memory. It shares the memory between instruction fetch (F), control-unit data load/store (D) and the external program loader/debug port (X). F and D are the two ports of `Control`. The block grants one access per cycle under rotating priority, drives the memory command port and returns read data with one cycle of latency. X can lock the port to halt the CPU while it loads a program.

## Interface
Parameters:
- `ADDR_W`, 16: address width, covering 64 KiB.
- `DATA_W`, 8: data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch read request.
- `f_addr`  in  ADDR_W  fetch address.
- `f_gnt`  out  1  fetch granted this cycle.
- `f_rvalid`  out  1  `rdata` holds fetch data.
- `d_req`, `d_we`  in  1 each  data request; 1 = write.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  data write value.
- `d_gnt`, `d_rvalid`  out  1 each  data grant and read-valid.
- `x_req`, `x_we`, `x_lock`  in  1 each  loader request, write enable, bus lock.
- `x_addr`  in  ADDR_W  loader address.
- `x_wdata`  in  DATA_W  loader write value.
- `x_gnt`, `x_rvalid`  out  1 each  loader grant and read-valid.
- `rdata`  out  DATA_W  shared read-return bus; this is `mem_rdata` passed through.
- `mem_en`, `mem_we`  out  1 each  memory command strobe and write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid the cycle after a read command.

## Operation
- Arbitration is combinational from the `*_req` inputs and the registered state. At most one `*_gnt` is high in any cycle.
- A transaction completes at the rising edge where its `gnt` is high.
- Requesters hold req, addr, we and wdata stable until they see `gnt`. A requester may drop `req` without being granted; no access occurs in that case.
- F is read-only; the fetch path has no write enable.
- Round-robin pointer `rr` ∈ {F, D, X}, reset to F:
  - Search order starts at `rr` and wraps F→D→X→F.
  - After a grant to requester i, `rr` becomes i+1 (mod 3).
  - With no grant, `rr` holds.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED→LOCKED at the edge where `x_gnt` and `x_lock` are both 1.
  - In LOCKED only X can be granted. F and D wait even when `x_req` = 0, and `rr` does not advance.
  - LOCKED→UNLOCKED at the first edge where `x_lock` = 0. F and D become grantable in the following cycle.
- Memory command:
  - `mem_en` = any gnt.
  - `mem_addr`, `mem_we` and `mem_wdata` come from the winner.
  - When idle, `mem_addr`, `mem_we` and `mem_wdata` are 0.
- Read return:
  - A registered owner tag records {requester, read}.
  - The next cycle, the matching `*_rvalid` = 1 for exactly one cycle.
  - Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. The rvalid of access n coincides with the gnt of access n+1.

## Timing
- Reset (`rst` = 0, asynchronous):
  - All `*_gnt`, `*_rvalid`, `mem_en` and `mem_we` are 0.
  - `mem_addr` and `mem_wdata` are 0. `rdata` follows `mem_rdata`.
  - `rr` = F, FSM = UNLOCKED, owner tag cleared.
- Reset asserted mid-transaction: any pending rvalid is discarded and the lock is released. Requesters re-request after reset deasserts.
- Grant latency is 0 cycles when uncontested. Worst-case wait when unlocked is 2 cycles.
- Read latency: data is on `rdata` with `*_rvalid` exactly 1 cycle after the granting edge.
- Throughput: one access per cycle.
- Simultaneous `x_req` & `x_lock` with F and D also pending, `rr` = F: F is granted first. X locks only when it actually wins.

## Test plan
- Release reset, all three requests held, D and X reads at addresses 0x0010 and 0x0020:
  - Required: `f_gnt`, then `d_gnt`, then `x_gnt` on consecutive cycles, then F again.
  - Required: each rvalid is 1 cycle after its gnt, with `rdata` = memory contents.
- D writes 0xBA to 0x00BA, then F reads 0x00BA:
  - Required: `mem_we` = 1 for 1 cycle only, no `d_rvalid`.
  - Required: `f_rvalid` with `rdata` = 0xBA.
- X with `x_lock` writes 0x00–0x04, idle gaps between writes, F requesting throughout:
  - Required: `f_gnt` = 0 until the cycle after `x_lock` falls, then F is granted.
- Only F requests continuously for 8 cycles:
  - Required: `f_gnt` = 1 every cycle, 8 `f_rvalid` pulses, `rr` stays correct (next D request is granted immediately).
- Drive `rst` low in the cycle between a D read grant and its return:
  - Required: `d_rvalid` stays 0, all outputs are at reset values, lock is cleared.
- D drops `d_req` before winning while F and X contend:
  - Required: no D access issued, `rr` unaffected by D.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Rotating-priority arbiter for the single-port system memory shared by fetch (F),
// data load/store (D) and the external loader (X); X can lock out F and D.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              x_req,
  input  logic              x_we,
  input  logic              x_lock,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {PORT_F = 2'd0, PORT_D = 2'd1, PORT_X = 2'd2} port_e;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

  function automatic port_e nextPort(input port_e p);
    case (p)
      PORT_F:  return PORT_D;
      PORT_D:  return PORT_X;
      default: return PORT_F;
    endcase
  endfunction

  port_e      rr, rrNext;
  lock_e      lockState, lockNext;
  logic       tagValid, tagValidNext;
  port_e      tagOwner, tagOwnerNext;
  logic       winnerValid;
  port_e      winner;
  port_e      cand;
  logic [2:0] reqVec;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    winnerValid  = 1'b0;
    winner       = PORT_F;
    cand         = rr;
    reqVec       = {x_req, d_req, f_req};
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    rrNext       = rr;
    lockNext     = lockState;
    tagValidNext = 1'b0;
    tagOwnerNext = tagOwner;

    if (lockState == LOCKED) begin
      winnerValid = x_req;
      winner      = PORT_X;
    end else begin
      // Search starts at rr and wraps F -> D -> X.
      for (int k = 0; k < 3; k++) begin
        if (!winnerValid && reqVec[cand]) begin
          winnerValid = 1'b1;
          winner      = cand;
        end
        cand = nextPort(cand);
      end
    end
    if (!rst) winnerValid = 1'b0;

    if (winnerValid) begin
      mem_en = 1'b1;
      case (winner)
        PORT_F: mem_addr = f_addr;
        PORT_D: begin
          mem_addr  = d_addr;
          mem_we    = d_we;
          mem_wdata = d_wdata;
        end
        default: begin
          mem_addr  = x_addr;
          mem_we    = x_we;
          mem_wdata = x_wdata;
        end
      endcase
      tagValidNext = !mem_we;
      tagOwnerNext = winner;
      if (lockState == UNLOCKED) rrNext = nextPort(winner);
    end

    case (lockState)
      UNLOCKED: if (winnerValid && winner == PORT_X && x_lock) lockNext = LOCKED;
      default:  if (!x_lock) lockNext = UNLOCKED;
    endcase
  end

  assign f_gnt    = winnerValid && (winner == PORT_F);
  assign d_gnt    = winnerValid && (winner == PORT_D);
  assign x_gnt    = winnerValid && (winner == PORT_X);
  assign f_rvalid = tagValid && (tagOwner == PORT_F);
  assign d_rvalid = tagValid && (tagOwner == PORT_D);
  assign x_rvalid = tagValid && (tagOwner == PORT_X);
  assign rdata    = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr        <= PORT_F;
      lockState <= UNLOCKED;
      tagValid  <= 1'b0;
      tagOwner  <= PORT_F;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      rr        <= rrNext;
      lockState <= lockNext;
      tagValid  <= tagValidNext;
      tagOwner  <= tagOwnerNext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory whose
// unwritten locations read back as addr[7:0] ^ addr[15:8] ^ 8'h5A.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_gnt, f_rvalid;
  logic [15:0] f_addr;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [15:0] d_addr;
  logic [7:0]  d_wdata;
  logic        x_req, x_we, x_lock, x_gnt, x_rvalid;
  logic [15:0] x_addr;
  logic [7:0]  x_wdata;
  logic [7:0]  rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .x_req(x_req), .x_we(x_we), .x_lock(x_lock), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, writes stored in a sparse overlay.
  logic [7:0] memArr [0:65535];
  bit         written [0:65535];
  logic [7:0] rdataReg;
  assign mem_rdata = rdataReg;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        memArr[mem_addr]  <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        rdataReg <= written[mem_addr] ? memArr[mem_addr]
                                      : (mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h5A);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    x_req = 1'b0; x_we = 1'b0; x_lock = 1'b0; x_addr = '0; x_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nRvalid;
    rst = 1'b0;
    setIdle();
    f_req = 1'b1;
    #2;
    check("rst gnt",    {f_gnt, d_gnt, x_gnt}, 3'b000);
    check("rst rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b000);
    check("rst mem",    {mem_en, mem_we, mem_addr, mem_wdata}, '0);
    tick();
    tick();

    // Rotation with all three requesters held: F, D, X, F.
    rst = 1'b1;
    f_req = 1'b1; f_addr = 16'h0000;
    d_req = 1'b1; d_addr = 16'h0010;
    x_req = 1'b1; x_addr = 16'h0020;
    #1;
    check("rot0 gnt", {f_gnt, d_gnt, x_gnt}, 3'b100);
    check("rot0 addr", mem_addr, 16'h0000);
    tick(); #1;
    check("rot1 gnt", {f_gnt, d_gnt, x_gnt}, 3'b010);
    check("rot1 rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b100);
    check("rot1 rdata", rdata, 8'h5A);
    check("rot1 addr", mem_addr, 16'h0010);
    tick(); #1;
    check("rot2 gnt", {f_gnt, d_gnt, x_gnt}, 3'b001);
    check("rot2 rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b010);
    check("rot2 rdata", rdata, 8'h4A);
    tick(); #1;
    check("rot3 gnt", {f_gnt, d_gnt, x_gnt}, 3'b100);
    check("rot3 rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b001);
    check("rot3 rdata", rdata, 8'h7A);
    tick(); setIdle(); #1;
    check("rot4 idle", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
    check("rot4 rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b100);
    check("rot4 rdata", rdata, 8'h5A);

    // D write then F read-back of the same location.
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h00BA; d_wdata = 8'hBA;
    #1;
    check("dwr gnt", {f_gnt, d_gnt, x_gnt}, 3'b010);
    check("dwr cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h00BA, 8'hBA});
    tick();
    setIdle(); f_req = 1'b1; f_addr = 16'h00BA;
    #1;
    check("frd gnt", {f_gnt, d_gnt, x_gnt}, 3'b100);
    check("frd we", mem_we, 1'b0);
    check("dwr no rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b000);
    tick(); setIdle(); #1;
    check("frd rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b100);
    check("frd rdata", rdata, 8'hBA);

    // Locked loader writes with idle gaps; F keeps requesting.
    for (int i = 0; i < 5; i++) begin
      tick();
      x_req = 1'b1; x_we = 1'b1; x_lock = 1'b1;
      x_addr = 16'(16'h0100 + i); x_wdata = 8'(i);
      f_req = 1'b1; f_addr = 16'h0200;
      #1;
      check("lock wr gnt", {f_gnt, d_gnt, x_gnt}, 3'b001);
      check("lock wr cmd", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'(16'h0100 + i), 8'(i)});
      tick();
      x_req = 1'b0;
      #1;
      check("lock gap gnt", {f_gnt, d_gnt, x_gnt}, 3'b000);
      check("lock gap rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b000);
    end
    tick(); x_lock = 1'b0; #1;
    check("unlock edge gnt", {f_gnt, d_gnt, x_gnt}, 3'b000);
    tick(); #1;
    check("unlocked f gnt", {f_gnt, d_gnt, x_gnt}, 3'b100);
    tick(); setIdle(); #1;
    check("unlocked f rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b100);
    check("unlocked f rdata", rdata, 8'h58);
    check("lock wr stored", memArr[16'h0104], 8'h04);

    // F alone for 8 back-to-back cycles.
    nRvalid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      f_req = 1'b1; f_addr = 16'(16'h0300 + i);
      #1;
      check("fstream gnt", {f_gnt, d_gnt, x_gnt}, 3'b100);
      if (f_rvalid) nRvalid++;
      if (i > 0) check("fstream rdata", rdata, 8'(8'h59 ^ (i - 1)));
    end
    tick(); setIdle(); #1;
    if (f_rvalid) nRvalid++;
    check("fstream last rdata", rdata, 8'h5E);
    check("fstream rvalid count", nRvalid, 8);

    // rr must now point at D: D wins against F and X.
    tick();
    f_req = 1'b1; f_addr = 16'h0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    x_req = 1'b1; x_we = 1'b0; x_addr = 16'h0020;
    #1;
    check("rr after fstream", {f_gnt, d_gnt, x_gnt}, 3'b010);

    // Reset between the D read grant and its return.
    tick(); rst = 1'b0; #1;
    check("midrst rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b000);
    check("midrst gnt", {f_gnt, d_gnt, x_gnt}, 3'b000);
    check("midrst mem", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
    check("midrst rdata passthru", rdata, mem_rdata);
    tick();
    rst = 1'b1; setIdle();
    x_req = 1'b1; x_lock = 1'b1; x_addr = 16'h0020;
    #1;
    check("lockgrab gnt", {f_gnt, d_gnt, x_gnt}, 3'b001);
    tick(); rst = 1'b0; #1;
    check("lockrst rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b000);
    tick();
    rst = 1'b1; x_req = 1'b0; x_lock = 1'b1; f_req = 1'b1; f_addr = 16'h0000;
    #1;
    check("lock cleared by rst", {f_gnt, d_gnt, x_gnt}, 3'b100);

    // D withdraws before winning while F and X contend.
    tick();
    setIdle(); d_req = 1'b1; d_addr = 16'h0010;
    #1;
    check("s0 gnt", {f_gnt, d_gnt, x_gnt}, 3'b010);
    check("s0 rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b100);
    tick();
    f_req = 1'b1; f_addr = 16'h0000; x_req = 1'b1; x_addr = 16'h0020;
    #1;
    check("s1 gnt", {f_gnt, d_gnt, x_gnt}, 3'b001);
    check("s1 rdata", rdata, 8'h4A);
    tick(); d_req = 1'b0; #1;
    check("s2 gnt", {f_gnt, d_gnt, x_gnt}, 3'b100);
    check("s2 rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b001);
    tick(); #1;
    check("s3 gnt", {f_gnt, d_gnt, x_gnt}, 3'b001);
    check("s3 rdata", rdata, 8'h5A);
    tick(); x_req = 1'b0; #1;
    check("s4 gnt", {f_gnt, d_gnt, x_gnt}, 3'b100);
    check("s4 rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b001);
    check("s4 rdata", rdata, 8'h7A);
    tick(); setIdle(); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
